mips_regfile: RTL and testbench



---
 rtl/mips_pkg.sv | 16 +
 rtl/mips_regfile_read_port.sv | 45 ++++
 rtl/mips_regfile.sv | 60 ++++++
 tb/tb_mips_regfile.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and register index constants.
// Used by the register file, ALU and decoder.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [WORD_W-1:0]     word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_AT   = 5'd1;
    localparam reg_idx_t REG_SP   = 5'd29;
    localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/mips_regfile_read_port.sv
// One combinational read port of the MIPS register file.
// Write-first forwarding only when MIPS_REGFILE_BYPASS_EN is defined.
module regfile_read_port
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_W,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] regs,
    input  logic [ADDR_WIDTH-1:0]                    rd_addr,
    input  logic                                     wr_ena,
    input  logic [ADDR_WIDTH-1:0]                    wr_addr,
    input  logic [DATA_WIDTH-1:0]                    wr_data,
    output logic [DATA_WIDTH-1:0]                    rd_data
);

`ifdef MIPS_REGFILE_BYPASS_EN
    logic fwd_hit;

    assign fwd_hit = wr_ena && (wr_addr != '0) && (wr_addr == rd_addr);

    always_comb begin
        rd_data = regs[rd_addr];
        if (fwd_hit) begin
            rd_data = wr_data;
        end
        // $0 wins over everything, including forwarding
        if (rd_addr == '0) begin
            rd_data = '0;
        end
    end
`else
    logic unused_wr;

    assign unused_wr = ^{wr_ena, wr_addr, wr_data};

    always_comb begin
        rd_data = regs[rd_addr];
        if (rd_addr == '0) begin
            rd_data = '0;
        end
    end
`endif

endmodule

// File: rtl/mips_regfile.sv
// 32x32 MIPS register file: two combinational reads, one sync write, $0 = 0.
// Optional write-first forwarding: define MIPS_REGFILE_BYPASS_EN.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_W,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [ADDR_WIDTH-1:0] rd_addr0,
    output logic [DATA_WIDTH-1:0] rd_data0,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    output logic [DATA_WIDTH-1:0] rd_data1,
    input  logic                  wr_ena,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
    logic                             wr_live;

    // Forwarding must not leak wr_data onto the read ports during reset
    assign wr_live = wr_ena & rstb;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            regs <= '0;
        end else if (wr_ena && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_port0 (
        .regs    (regs),
        .rd_addr (rd_addr0),
        .wr_ena  (wr_live),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data0)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_port1 (
        .regs    (regs),
        .rd_addr (rd_addr1),
        .wr_ena  (wr_live),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data1)
    );

endmodule

// File: tb/tb_mips_regfile.sv
// Self-checking bench for mips_regfile: array model plus directed vectors.
module tb_mips_regfile;
    import mips_pkg::*;

`ifdef MIPS_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic     clk = 1'b0;
    logic     rstb;
    reg_idx_t rd_addr0, rd_addr1, wr_addr;
    word_t    rd_data0, rd_data1, wr_data;
    logic     wr_ena;

    int    total = 0;
    int    bad   = 0;
    word_t model [32];
    word_t sum;

    mips_regfile dut (
        .clk      (clk),
        .rstb     (rstb),
        .rd_addr0 (rd_addr0),
        .rd_data0 (rd_data0),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < 32; i++) model[i] <= '0;
        end else if (wr_ena && wr_addr != 0) begin
            model[wr_addr] <= wr_data;
        end
    end

    function automatic word_t expect_rd(input reg_idx_t a);
        if (rstb !== 1'b1 || a == 0) return '0;
        if (BYP && wr_ena && wr_addr == a) return wr_data;
        return model[a];
    endfunction

    task automatic check(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("model_port0", rd_data0, expect_rd(rd_addr0));
        check("model_port1", rd_data1, expect_rd(rd_addr1));
    end

    always @(posedge clk) begin
        if (rstb === 1'b1 && wr_ena === 1'b1)
            assert (!$isunknown(wr_addr))
            else $error("FAIL wr_addr_x: got %b want known", wr_addr);
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input reg_idx_t a, input word_t d);
        wr_ena  = 1'b1;
        wr_addr = a;
        wr_data = d;
        sync();
        wr_ena  = 1'b0;
    endtask

    initial begin
        rstb     = 1'b0;
        wr_ena   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr0 = 5'd5;
        rd_addr1 = 5'd31;
        repeat (2) sync();
        check("reset_p0", rd_data0, 32'h0);
        check("reset_p1", rd_data1, 32'h0);
        rstb = 1'b1;
        sync();

        // async reset mid-cycle
        wr(5'd5, 32'hDEADBEEF);
        rd_addr0 = 5'd5;
        #1;
        check("r5_written", rd_data0, 32'hDEADBEEF);
        rstb = 1'b0;
        #1;
        check("r5_async_clr", rd_data0, 32'h0);
        #1;
        rstb = 1'b1;
        sync();
        check("r5_after_rel", rd_data0, 32'h0);

        // $0 immutability
        wr(5'd0, 32'hFFFFFFFF);
        rd_addr0 = 5'd0;
        rd_addr1 = 5'd0;
        #1;
        check("r0_p0", rd_data0, 32'h0);
        check("r0_p1", rd_data1, 32'h0);
        sync();

        // dual read feeding an ADD
        wr(5'd8, 32'h00000007);
        wr(5'd9, 32'hFFFFFFF9);
        rd_addr0 = 5'd8;
        rd_addr1 = 5'd9;
        #1;
        check("r8", rd_data0, 32'h00000007);
        check("r9", rd_data1, 32'hFFFFFFF9);
        check("model_r8", model[8], 32'h00000007);
        sum = rd_data0 + rd_data1;
        check("alu_add_z", sum, 32'h0);
        check("alu_zero", {31'b0, sum == 0}, 32'h1);
        sync();

        // wr_ena gating
        wr(5'd3, 32'h12345678);
        wr_addr = 5'd3;
        wr_data = 32'hAAAAAAAA;
        repeat (3) sync();
        rd_addr0 = 5'd3;
        #1;
        check("r3_hold", rd_data0, 32'h12345678);
        check("model_r3", model[3], 32'h12345678);
        sync();

        // read during write
        wr(5'd10, 32'h11111111);
        wr_ena   = 1'b1;
        wr_addr  = 5'd10;
        wr_data  = 32'h22222222;
        rd_addr0 = 5'd10;
        #1;
        check("rdw_before", rd_data0, BYP ? 32'h22222222 : 32'h11111111);
        sync();
        wr_ena = 1'b0;
        #1;
        check("rdw_after", rd_data0, 32'h22222222);
        sync();

        // full sweep
        for (int i = 1; i < 32; i++) wr(reg_idx_t'(i), word_t'(i) * 32'h01010101);
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = reg_idx_t'(i);
            rd_addr1 = reg_idx_t'(31 - i);
            #1;
            check("sweep_p0", rd_data0, word_t'(i) * 32'h01010101);
            check("sweep_p1", rd_data1, word_t'(31 - i) * 32'h01010101);
            sync();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
